// File: rtl/div_seq_unit.sv
// div_seq_unit: sequential signed divider returning MIPS `div` results.
// The quotient goes to LO and the remainder to HI. The datapath is a radix-2
// restoring divider on operand magnitudes, one quotient bit per cycle, followed
// by a sign-fix cycle. A zero divisor is flagged one cycle after the request
// and performs no arithmetic.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous, active-low; aborts any running operation
//   start     - request strobe, sampled only while idle
//   dividend  - signed rs value, latched on accepted start
//   divisor   - signed rt value, latched on accepted start
//   quotient  - signed quotient (LO), updated only when an operation completes
//   remainder - signed remainder (HI), updated only when an operation completes
//   busy      - high while an operation is in RUN or FIX
//   done      - one-cycle completion pulse
//   div_zero  - one-cycle pulse alongside done when the divisor was zero
module div_seq_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFix  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              sd_q, sd_d;
   logic              sv_q, sv_d;
   logic [WIDTH-1:0]  dvs_q, dvs_d;
   // The partial remainder is always below |divisor| <= 2^(WIDTH-1) between
   // steps, so WIDTH bits hold it; only the shifted value needs the extra bit.
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic [WIDTH-1:0]  qreg_q, qreg_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [WIDTH-1:0]  remainder_q, remainder_d;
   logic              done_q, done_d;
   logic              div_zero_q, div_zero_d;

   logic [WIDTH:0]    shifted;
   logic              trial_ge;

   // Restoring step on the shifted {rem, qreg} pair.
   always_comb begin
      shifted  = {rem_q, qreg_q[WIDTH-1]};
      trial_ge = (shifted >= {1'b0, dvs_q});
   end

   always_comb begin
      state_d     = state_q;
      sd_d        = sd_q;
      sv_d        = sv_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      qreg_d      = qreg_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      done_d      = 1'b0;
      div_zero_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (divisor == '0) begin
                  done_d     = 1'b1;
                  div_zero_d = 1'b1;
               end else begin
                  sd_d    = dividend[WIDTH-1];
                  sv_d    = divisor[WIDTH-1];
                  // Negating the most negative value wraps to itself, which
                  // is the correct unsigned magnitude.
                  qreg_d  = dividend[WIDTH-1] ? -dividend : dividend;
                  dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
                  rem_d   = '0;
                  cnt_d   = CntW'(WIDTH - 1);
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (trial_ge) begin
               rem_d = WIDTH'(shifted - {1'b0, dvs_q});
            end else begin
               rem_d = shifted[WIDTH-1:0];
            end
            qreg_d = {qreg_q[WIDTH-2:0], trial_ge};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = StFix;
            end
         end
         StFix: begin
            quotient_d  = (sd_q ^ sv_q) ? -qreg_q : qreg_q;
            remainder_d = sd_q ? -rem_q : rem_q;
            done_d      = 1'b1;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         sd_q        <= 1'b0;
         sv_q        <= 1'b0;
         dvs_q       <= '0;
         rem_q       <= '0;
         qreg_q      <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sd_q        <= sd_d;
         sv_q        <= sv_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         qreg_q      <= qreg_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign div_zero  = div_zero_q;

endmodule
